// File: rtl/weight_transposer.sv
// weight_transposer: buffers an NxM weight matrix row by row and writes
// its MxN transpose into the weight SRAM, one transposed row per address.
module weight_transposer #(
    parameter int DW  = 8,
    parameter int DIM = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     START,
    input  logic [3:0]               M,
    input  logic [3:0]               N,
    input  logic                     S_VALID,
    output logic                     S_READY,
    input  logic [DIM*DW-1:0]        S_DATA,
    output logic                     EN_W,
    output logic                     WE_W,
    output logic [$clog2(DIM)-1:0]   ADDR_W,
    output logic [DIM*DW-1:0]        WDATA_W,
    output logic                     BUSY,
    output logic                     DONE,
    output logic                     ERR
);

    localparam int AW = $clog2(DIM);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE
    } state_t;

    state_t             state;
    logic [3:0]         m_q;
    logic [3:0]         n_q;
    logic [AW-1:0]      row_q;
    logic [DW-1:0]      mem_q [DIM][DIM];
    logic [DW-1:0]      row_in [DIM];
    logic [DIM*DW-1:0]  first_col;
    logic [DIM*DW-1:0]  next_col;
    logic [AW-1:0]      next_addr;
    logic               cfg_ok;
    logic               beat;
    logic               last_row;

    assign cfg_ok   = (M != 4'd0) && (M <= 4'(DIM)) &&
                      (N != 4'd0) && (N <= 4'(DIM));
    assign beat     = S_VALID && S_READY;
    assign last_row = (4'(row_q) == (n_q - 4'd1));

    // Columns beyond M are forced to zero so the transposed rows i>=M stay empty.
    always_comb begin
        next_addr = ADDR_W + AW'(1);
        first_col = '0;
        next_col  = '0;
        for (int j = 0; j < DIM; j++) begin
            row_in[j] = (4'(j) < m_q) ? S_DATA[(DIM-1-j)*DW +: DW] : '0;
        end
        for (int k = 0; k < DIM; k++) begin
            first_col[(DIM-1-k)*DW +: DW] =
                (AW'(k) == row_q) ? row_in[0] : mem_q[k][0];
            next_col[(DIM-1-k)*DW +: DW] = mem_q[k][next_addr];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            m_q     <= '0;
            n_q     <= '0;
            row_q   <= '0;
            S_READY <= 1'b0;
            EN_W    <= 1'b0;
            WE_W    <= 1'b0;
            ADDR_W  <= '0;
            WDATA_W <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            ERR     <= 1'b0;
            for (int k = 0; k < DIM; k++) begin
                for (int j = 0; j < DIM; j++) begin
                    mem_q[k][j] <= '0;
                end
            end
        end else begin
            DONE <= 1'b0;
            ERR  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (START) begin
                        if (cfg_ok) begin
                            m_q     <= M;
                            n_q     <= N;
                            row_q   <= '0;
                            S_READY <= 1'b1;
                            BUSY    <= 1'b1;
                            state   <= LOAD;
                            for (int k = 0; k < DIM; k++) begin
                                for (int j = 0; j < DIM; j++) begin
                                    mem_q[k][j] <= '0;
                                end
                            end
                        end else begin
                            ERR <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (beat) begin
                        for (int j = 0; j < DIM; j++) begin
                            mem_q[row_q][j] <= row_in[j];
                        end
                        row_q <= row_q + AW'(1);
                        // The first write goes out right away, so column 0
                        // must include the row arriving on this beat.
                        if (last_row) begin
                            state   <= WRITE;
                            S_READY <= 1'b0;
                            EN_W    <= 1'b1;
                            WE_W    <= 1'b1;
                            ADDR_W  <= '0;
                            WDATA_W <= first_col;
                        end
                    end
                end
                WRITE: begin
                    if (ADDR_W == AW'(DIM-1)) begin
                        state   <= IDLE;
                        EN_W    <= 1'b0;
                        WE_W    <= 1'b0;
                        ADDR_W  <= '0;
                        WDATA_W <= '0;
                        BUSY    <= 1'b0;
                        DONE    <= 1'b1;
                    end else begin
                        ADDR_W  <= next_addr;
                        WDATA_W <= next_col;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_we_en: assert property (@(posedge CLK) WE_W == EN_W);
    a_en_busy: assert property (@(posedge CLK) EN_W |-> BUSY);

endmodule

// File: tb/tb_weight_transposer.sv
// tb_weight_transposer: random and directed jobs checked against a
// transpose model built from the input rows.
module tb_weight_transposer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic [3:0]  M;
    logic [3:0]  N;
    logic        S_VALID;
    logic        S_READY;
    logic [63:0] S_DATA;
    logic        EN_W;
    logic        WE_W;
    logic [2:0]  ADDR_W;
    logic [63:0] WDATA_W;
    logic        BUSY;
    logic        DONE;
    logic        ERR;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int bad_we = 0;

    int          wr_cyc [$];
    int          wr_addr [$];
    logic [63:0] wr_data [$];
    int          done_q [$];
    int          err_q [$];

    weight_transposer #(.DW(8), .DIM(8)) dut (
        .CLK(CLK),
        .RST(RST),
        .START(START),
        .M(M),
        .N(N),
        .S_VALID(S_VALID),
        .S_READY(S_READY),
        .S_DATA(S_DATA),
        .EN_W(EN_W),
        .WE_W(WE_W),
        .ADDR_W(ADDR_W),
        .WDATA_W(WDATA_W),
        .BUSY(BUSY),
        .DONE(DONE),
        .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (EN_W) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(int'(ADDR_W));
            wr_data.push_back(WDATA_W);
        end
        if (WE_W !== EN_W) bad_we++;
        if (DONE) done_q.push_back(cyc);
        if (ERR) err_q.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic clear_mon();
        wr_cyc.delete();
        wr_addr.delete();
        wr_data.delete();
        done_q.delete();
        err_q.delete();
        bad_we = 0;
    endtask

    // vmode: 0 always valid, 1 pattern 1,0,0,..., 2 random valid
    task automatic run_job(input int m, input int n,
                           input logic [63:0] rows [8],
                           input int vmode, input bit inj);
        logic [63:0] exp [8];
        int s_cyc, u_cyc, beats, tries, ph;
        bit v, rdy, injected;
        for (int i = 0; i < 8; i++) begin
            exp[i] = '0;
            for (int k = 0; k < 8; k++)
                if (i < m && k < n)
                    exp[i][(7-k)*8 +: 8] = rows[k][(7-i)*8 +: 8];
        end
        clear_mon();
        @(negedge CLK);
        START = 1'b1;
        M = 4'(m);
        N = 4'(n);
        @(negedge CLK);
        START = 1'b0;
        s_cyc = cyc;
        chk("busy_up", 64'(BUSY), 64'd1);
        chk("ready_up", 64'(S_READY), 64'd1);
        beats = 0;
        tries = 0;
        ph = 0;
        injected = 1'b0;
        while (beats < n && tries < 300) begin
            case (vmode)
                0: v = 1'b1;
                1: v = (ph % 3 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            ph++;
            S_VALID = v;
            S_DATA = rows[beats];
            if (inj && !injected && beats == 1) begin
                START = 1'b1;
                M = 4'd1;
                N = 4'd1;
                injected = 1'b1;
            end
            rdy = S_READY;
            @(negedge CLK);
            START = 1'b0;
            if (v && rdy) beats++;
            tries++;
        end
        chk("beats", 64'(beats), 64'(n));
        S_VALID = 1'b0;
        S_DATA = {$urandom, $urandom};
        u_cyc = cyc;
        chk("ready_dn", 64'(S_READY), 64'd0);
        if (inj) begin
            repeat (3) @(negedge CLK);
            START = 1'b1;
            M = 4'd1;
            N = 4'd1;
            @(negedge CLK);
            START = 1'b0;
        end
        tries = 0;
        while (done_q.size() == 0 && tries < 30) begin
            @(negedge CLK);
            tries++;
        end
        repeat (3) @(negedge CLK);
        chk("done_cnt", 64'(done_q.size()), 64'd1);
        if (done_q.size() > 0) begin
            chk("done_cyc", 64'(done_q[0]), 64'(u_cyc + 8));
            if (vmode == 0)
                chk("latency", 64'(done_q[0] - s_cyc), 64'(n + 8));
        end
        chk("n_writes", 64'(wr_addr.size()), 64'd8);
        for (int i = 0; i < wr_addr.size() && i < 8; i++) begin
            chk($sformatf("addr%0d", i), 64'(wr_addr[i]), 64'(i));
            chk($sformatf("wcyc%0d", i), 64'(wr_cyc[i]), 64'(u_cyc + i));
            chk($sformatf("data%0d", i), wr_data[i], exp[i]);
        end
        chk("we_eq_en", 64'(bad_we), 64'd0);
        chk("no_err", 64'(err_q.size()), 64'd0);
        chk("busy_dn", 64'(BUSY), 64'd0);
    endtask

    task automatic bad_start(input int m, input int n);
        clear_mon();
        @(negedge CLK);
        START = 1'b1;
        M = 4'(m);
        N = 4'(n);
        @(negedge CLK);
        START = 1'b0;
        chk("err_pulse", 64'(ERR), 64'd1);
        chk("err_busy", 64'(BUSY), 64'd0);
        repeat (4) @(negedge CLK);
        chk("err_once", 64'(err_q.size()), 64'd1);
        chk("err_nowr", 64'(wr_addr.size()), 64'd0);
        chk("err_idle", 64'(BUSY), 64'd0);
        chk("err_rdy", 64'(S_READY), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] rows [8];
        int m, n;

        RST = 1'b1;
        START = 1'b0;
        M = '0;
        N = '0;
        S_VALID = 1'b0;
        S_DATA = '0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_ready", 64'(S_READY), 64'd0);
        chk("rst_en", 64'(EN_W), 64'd0);
        chk("rst_we", 64'(WE_W), 64'd0);
        chk("rst_addr", 64'(ADDR_W), 64'd0);
        chk("rst_wdata", WDATA_W, 64'd0);
        chk("rst_busy", 64'(BUSY), 64'd0);
        chk("rst_done", 64'(DONE), 64'd0);
        chk("rst_err", 64'(ERR), 64'd0);

        for (int r = 0; r < 8; r++) rows[r] = 64'h80 << (8 * (7 - r));
        run_job(8, 8, rows, 0, 1'b0);

        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                rows[r][(7-c)*8 +: 8] = (c < 5) ? 8'(16 * (r + 1) + c + 1)
                                                : 8'hFF;
        run_job(5, 6, rows, 0, 1'b0);

        for (int r = 0; r < 8; r++) rows[r] = {$urandom, $urandom};
        run_job(4, 4, rows, 1, 1'b0);

        bad_start(0, 3);
        bad_start(3, 9);

        for (int r = 0; r < 8; r++) rows[r] = {$urandom, $urandom};
        run_job(6, 7, rows, 0, 1'b1);

        clear_mon();
        @(negedge CLK);
        START = 1'b1;
        M = 4'd8;
        N = 4'd8;
        @(negedge CLK);
        START = 1'b0;
        S_VALID = 1'b1;
        S_DATA = 64'hDEAD_BEEF_CAFE_F00D;
        repeat (3) @(negedge CLK);
        S_VALID = 1'b0;
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        repeat (5) @(negedge CLK);
        chk("rst_mid_nowr", 64'(wr_addr.size()), 64'd0);
        chk("rst_mid_busy", 64'(BUSY), 64'd0);
        chk("rst_mid_rdy", 64'(S_READY), 64'd0);
        for (int r = 0; r < 8; r++) rows[r] = {$urandom, $urandom};
        run_job(2, 2, rows, 0, 1'b0);

        for (int t = 0; t < 10; t++) begin
            m = $urandom_range(1, 8);
            n = $urandom_range(1, 8);
            for (int r = 0; r < 8; r++) rows[r] = {$urandom, $urandom};
            run_job(m, n, rows, 2, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
